// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns for hex digits.
package ssd_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'h7F;

   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low segment pattern.
module ssd_hex_decoder (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   import ssd_pkg::*;

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scanner.sv
// Multiplexed seven-segment scanner with tear-free valid/ready update, decimal points and PWM dimming.
// Optional leading-zero blanking is compiled in when SSD_LZ_BLANK_EN is defined.
module ssd_scanner #(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_CYCLES = 100000,
   parameter int BRIGHT_BITS    = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [4*NUM_DIGITS-1:0]   val_in,
   input  logic                      val_valid_in,
   output logic                      val_ready_out,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz_in,
   input  logic [BRIGHT_BITS-1:0]    brightness_in,
   output logic [6:0]                cat_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     an_out
);
   import ssd_pkg::*;

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DWELL_W = $clog2(REFRESH_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(REFRESH_CYCLES - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] pending_val_reg, display_val_reg;
   logic [NUM_DIGITS-1:0]   pending_dp_reg, display_dp_reg;
   logic                    pending_full_reg;
   logic                    run_reg;
   logic [DWELL_W-1:0]      dwell_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [BRIGHT_BITS-1:0]  pwm_reg;
   logic [NUM_DIGITS-1:0]   an_reg;
   logic [6:0]              cat_reg;
   logic                    dp_reg;

   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [3:0]              cur_nib;
   seg_t                    cur_seg;
   logic                    dwell_last, frame_end, accept, lit;

   // run_reg keeps ready low through reset and for the release edge itself
   assign val_ready_out = run_reg && !pending_full_reg;
   assign accept        = val_valid_in && val_ready_out;
   assign dwell_last    = (dwell_reg == DWELL_LAST);
   assign frame_end     = dwell_last && (idx_reg == IDX_LAST);
   assign cur_nib       = display_val_reg[{idx_reg, 2'b00} +: 4];
   assign lit           = (pwm_reg <= brightness_in) && !blank_mask[idx_reg];

   ssd_hex_decoder u_dec (
      .nibble (cur_nib),
      .seg    (cur_seg)
   );

`ifdef SSD_LZ_BLANK_EN
   // zero_up[i]: nibbles i..top all zero, evaluated on the frame-stable display register
   logic [NUM_DIGITS-1:1] zero_up;

   assign blank_mask[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign zero_up[gi] = (display_val_reg[4*gi +: 4] == 4'h0);
         end else begin : g_mid
            assign zero_up[gi] = (display_val_reg[4*gi +: 4] == 4'h0) && zero_up[gi+1];
         end
         assign blank_mask[gi] = blank_lz_in && zero_up[gi];
      end
   endgenerate
`else
   logic unused_blank_lz;

   assign unused_blank_lz = blank_lz_in;
   assign blank_mask      = '0;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         pending_val_reg  <= '0;
         pending_dp_reg   <= '0;
         pending_full_reg <= 1'b0;
         display_val_reg  <= '0;
         display_dp_reg   <= '0;
         run_reg          <= 1'b0;
         dwell_reg        <= '0;
         idx_reg          <= '0;
         pwm_reg          <= '0;
         an_reg           <= '1;
         cat_reg          <= SEG_OFF;
         dp_reg           <= 1'b1;
      end else begin
         run_reg <= 1'b1;
         pwm_reg <= pwm_reg + 1'b1;
         dwell_reg <= dwell_last ? '0 : dwell_reg + 1'b1;
         if (dwell_last) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
         end

         // accept and frame-end copy are mutually exclusive because ready is low while full
         if (accept) begin
            pending_val_reg  <= val_in;
            pending_dp_reg   <= dp_in;
            pending_full_reg <= 1'b1;
         end else if (frame_end && pending_full_reg) begin
            display_val_reg  <= pending_val_reg;
            display_dp_reg   <= pending_dp_reg;
            pending_full_reg <= 1'b0;
         end

         if (lit) begin
            an_reg  <= ~(NUM_DIGITS'(1) << idx_reg);
            cat_reg <= cur_seg;
            dp_reg  <= ~display_dp_reg[idx_reg];
         end else begin
            an_reg  <= '1;
            cat_reg <= SEG_OFF;
            dp_reg  <= 1'b1;
         end
      end
   end

   assign an_out  = an_reg;
   assign cat_out = cat_reg;
   assign dp_out  = dp_reg;

endmodule

// File: tb/tb_ssd_scanner.sv
// Directed bench for ssd_scanner (8 digits, dwell 4, 2-bit brightness); expectations follow SSD_LZ_BLANK_EN.
module tb_ssd_scanner;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] val_in = '0;
   logic        val_valid_in = 1'b0;
   logic        val_ready_out;
   logic [7:0]  dp_in = '0;
   logic        blank_lz_in = 1'b0;
   logic [1:0]  brightness_in = 2'd3;
   logic [6:0]  cat_out;
   logic        dp_out;
   logic [7:0]  an_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] loaded_val = '0;
   logic [7:0]  loaded_dp = '0;

   typedef struct {
      logic [31:0] val;
      logic [7:0]  dp;
      logic        blank;
      logic [1:0]  bright;
      int          digit;
      int          phase;
      logic [7:0]  an;
      logic [6:0]  cat;
      logic        dpo;
   } vec_t;

   vec_t vecs[$];

   ssd_scanner #(
      .NUM_DIGITS     (8),
      .REFRESH_CYCLES (4),
      .BRIGHT_BITS    (2)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .val_in        (val_in),
      .val_valid_in  (val_valid_in),
      .val_ready_out (val_ready_out),
      .dp_in         (dp_in),
      .blank_lz_in   (blank_lz_in),
      .brightness_in (brightness_in),
      .cat_out       (cat_out),
      .dp_out        (dp_out),
      .an_out        (an_out)
   );

   always #5 clk_in = ~clk_in;

   // edges since reset release; outputs sampled after edge t reflect counter slot t-1
   always @(posedge clk_in) begin
      if (!rst_in) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!val_ready_out && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      if (!val_ready_out) check({name, " ready timeout"}, 32'd0, 32'd1);
   endtask

   // handshake one value, then wait until the frame-end copy frees the slot
   task automatic send_and_wait(input logic [31:0] v, input logic [7:0] d);
      val_in = v;
      dp_in = d;
      val_valid_in = 1'b1;
      wait_ready("send");
      @(posedge clk_in);
      #1 val_valid_in = 1'b0;
      @(negedge clk_in);
      wait_ready("copy");
      loaded_val = v;
      loaded_dp = d;
      $display("sent val=%h dp=%h, displayed from cyc %0d", v, d, cyc);
   endtask

   task automatic wait_slot(input int digit, input int phase);
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while ((((cyc - 1) % 32) != digit * 4 + phase) && n < 100);
      if (n >= 100) check("slot timeout", 32'd0, 32'd1);
   endtask

   // 32 cycles: every lit cycle must show exp_cat on a single digit; count lit cycles
   task automatic check_frame(input string name, input logic [6:0] exp_cat, input int exp_lit);
      int bad = 0;
      int lit = 0;
      repeat (32) begin
         @(negedge clk_in);
         if ($countones(~an_out) > 1) bad++;
         if (an_out != 8'hFF) begin
            lit++;
            if (cat_out !== exp_cat) bad++;
         end
      end
      check({name, " mix"}, bad, 0);
      check({name, " lit"}, lit, exp_lit);
      $display("frame %s: lit=%0d bad=%0d", name, lit, bad);
   endtask

   initial begin
      int bad;
      int n;
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd3, 0, 0, 8'hFE, 7'h40, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd3, 3, 2, 8'hF7, 7'h30, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd3, 5, 1, 8'hDF, 7'h12, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd3, 7, 3, 8'h7F, 7'h78, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd0, 2, 0, 8'hFB, 7'h24, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd0, 2, 1, 8'hFF, 7'h7F, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd2, 4, 2, 8'hEF, 7'h19, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd2, 4, 3, 8'hFF, 7'h7F, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd1, 6, 1, 8'hBF, 7'h02, 1'b1});
      vecs.push_back('{32'h76543210, 8'h00, 1'b0, 2'd1, 6, 2, 8'hFF, 7'h7F, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 0, 0, 8'hFE, 7'h00, 1'b0});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 1, 1, 8'hFD, 7'h10, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 2, 0, 8'hFB, 7'h08, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 3, 0, 8'hF7, 7'h03, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 4, 0, 8'hEF, 7'h46, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 5, 0, 8'hDF, 7'h21, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 6, 0, 8'hBF, 7'h06, 1'b1});
      vecs.push_back('{32'hFEDCBA98, 8'h01, 1'b0, 2'd3, 7, 0, 8'h7F, 7'h0E, 1'b1});
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 0, 0, 8'hFE, 7'h12, 1'b1});
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 1, 0, 8'hFD, 7'h40, 1'b1});
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 2, 0, 8'hFB, 7'h08, 1'b1});
`ifdef SSD_LZ_BLANK_EN
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 3, 0, 8'hFF, 7'h7F, 1'b1});
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 7, 0, 8'hFF, 7'h7F, 1'b1});
`else
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 3, 0, 8'hF7, 7'h40, 1'b1});
      vecs.push_back('{32'h00000A05, 8'h80, 1'b1, 2'd3, 7, 0, 8'h7F, 7'h40, 1'b0});
`endif
      vecs.push_back('{32'h00000A05, 8'h80, 1'b0, 2'd3, 7, 0, 8'h7F, 7'h40, 1'b0});
      vecs.push_back('{32'h00000A05, 8'h80, 1'b0, 2'd3, 3, 0, 8'hF7, 7'h40, 1'b1});
      vecs.push_back('{32'h00000000, 8'h00, 1'b1, 2'd3, 0, 0, 8'hFE, 7'h40, 1'b1});
`ifdef SSD_LZ_BLANK_EN
      vecs.push_back('{32'h00000000, 8'h00, 1'b1, 2'd3, 1, 0, 8'hFF, 7'h7F, 1'b1});
`else
      vecs.push_back('{32'h00000000, 8'h00, 1'b1, 2'd3, 1, 0, 8'hFD, 7'h40, 1'b1});
`endif

      // reset held for three edges, release, ready rises one edge later
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst an", an_out, 8'hFF);
      check("rst cat", cat_out, 7'h7F);
      check("rst dp", dp_out, 1'b1);
      check("rst ready", val_ready_out, 1'b0);
      rst_in = 1'b1;
      #1 check("ready at release", val_ready_out, 1'b0);
      @(negedge clk_in);
      check("ready after release", val_ready_out, 1'b1);

      foreach (vecs[i]) begin
         blank_lz_in = vecs[i].blank;
         brightness_in = vecs[i].bright;
         if (vecs[i].val != loaded_val || vecs[i].dp != loaded_dp)
            send_and_wait(vecs[i].val, vecs[i].dp);
         wait_slot(vecs[i].digit, vecs[i].phase);
         $display("vec %0d: digit %0d phase %0d an=%h cat=%h dp=%b",
                  i, vecs[i].digit, vecs[i].phase, an_out, cat_out, dp_out);
         check($sformatf("vec%0d an", i), an_out, vecs[i].an);
         check($sformatf("vec%0d cat", i), cat_out, vecs[i].cat);
         check($sformatf("vec%0d dp", i), dp_out, vecs[i].dpo);
      end

      // tear-free: 2s accepted mid-frame, 3s held off while pending is full
      blank_lz_in = 1'b0;
      brightness_in = 2'd3;
      send_and_wait(32'h11111111, 8'h00);
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while ((cyc % 32) != 10 && n < 100);
      val_in = 32'h22222222;
      val_valid_in = 1'b1;
      @(posedge clk_in);
      #1 val_in = 32'h33333333;
      bad = 0;
      n = 0;
      @(negedge clk_in);
      while (!val_ready_out && n < 100) begin
         if (an_out != 8'hFF && cat_out !== 7'h79) bad++;
         @(negedge clk_in);
         n++;
      end
      check("tear old frame", bad, 0);
      check("ready after copy", val_ready_out, 1'b1);
      check("copy at frame end", cyc % 32, 0);
      @(posedge clk_in);
      #1 val_valid_in = 1'b0;
      check_frame("twos", 7'h24, 32);
      check_frame("threes", 7'h33 ^ 7'h03, 32);

      // reset while digit 5 is lit and pending holds 4s
      val_in = 32'h44444444;
      val_valid_in = 1'b1;
      wait_ready("mid");
      @(posedge clk_in);
      #1 val_valid_in = 1'b0;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (an_out != 8'hDF && n < 100);
      check("mid digit5 lit", an_out, 8'hDF);
      check("mid pending full", val_ready_out, 1'b0);
      rst_in = 1'b0;
      @(negedge clk_in);
      check("mid rst an", an_out, 8'hFF);
      check("mid rst cat", cat_out, 7'h7F);
      check("mid rst ready", val_ready_out, 1'b0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("mid restart digit0", an_out, 8'hFE);
      check("mid restart cat", cat_out, 7'h40);
      check("mid pending empty", val_ready_out, 1'b1);
      check_frame("zeros a", 7'h40, 32);
      check_frame("zeros b", 7'h40, 32);

      // duty: brightness 0 lights 1 of 4 cycles, 2 lights 3 of 4
      brightness_in = 2'd0;
      check_frame("duty0", 7'h40, 8);
      brightness_in = 2'd2;
      check_frame("duty2", 7'h40, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
